// File: rtl/perf_event_counter.sv
// perf_event_counter: performance-monitor block for core pipeline events.
// Counts NUM_EVENTS single-bit event strobes plus a cycle counter, either
// free-running (window_len = 0) or over a fixed window of cycles. Results are
// captured into shadow registers and read back through a registered mux.
//
// Optional feature: define PERF_IRQ_EN to build the window-complete interrupt.
// Without it, irq is tied low and no interrupt logic exists.
//
// State table:
//   IDLE | counters hold, waiting for start
//   RUN  | counting events and cycles; window counter decrements if nonzero
//   DONE | window elapsed, auto-snapshot taken, counters hold
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   event_in       per-channel event strobes, counted once per RUN cycle
//   start          pulse: begin/resume counting (reloads window)
//   stop           pulse: halt counting
//   clear          pulse: zero counters, shadows, overflow, snapshot_valid
//   window_len     window length sampled on an accepted start, 0 = free-run
//   snapshot_req   pulse: copy live counters to shadows
//   rd_sel         shadow select, NUM_EVENTS selects the cycle counter
//   rd_data        registered shadow value, one cycle after rd_sel
//   snapshot_valid shadows hold a completed snapshot
//   overflow       sticky saturation flags, bit NUM_EVENTS = cycle counter
//   running        high while in RUN
//   irq            window-complete interrupt
module perf_event_counter #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int WIN_WIDTH  = 16,
  parameter int SEL_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [WIN_WIDTH-1:0]  window_len,
  input  logic                  snapshot_req,
  input  logic [SEL_WIDTH-1:0]  rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  snapshot_valid,
  output logic [NUM_EVENTS:0]   overflow,
  output logic                  running,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [WIN_WIDTH-1:0] WIN_ONE = 1;

  state_t state_q, state_d;

  // Index NUM_EVENTS of the counter/shadow arrays is the cycle counter, so
  // one saturating-increment loop handles all channels.
  logic [CNT_WIDTH-1:0] cnt_q    [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] cnt_nxt  [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS+1];
  logic [NUM_EVENTS:0]  inc;
  logic [NUM_EVENTS:0]  ovf_set;
  logic [WIN_WIDTH-1:0] win_rem;
  logic [CNT_WIDTH-1:0] rd_mux;
  logic                 count_en;
  logic                 win_dec;
  logic                 win_load;
  logic                 auto_snap;

  assign inc = {1'b1, event_in};

  // clear pre-empts every transition, including a start in the same cycle.
  always_comb begin
    state_d   = state_q;
    count_en  = 1'b0;
    win_dec   = 1'b0;
    win_load  = 1'b0;
    auto_snap = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clear && !stop && start) begin
          state_d  = RUN;
          win_load = 1'b1;
        end
      end
      RUN: begin
        if (!clear) begin
          if (stop) begin
            state_d = IDLE;
          end else begin
            count_en = 1'b1;
            if (win_rem != '0) begin
              win_dec = 1'b1;
              if (win_rem == WIN_ONE) begin
                state_d   = DONE;
                auto_snap = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        if (!clear) begin
          if (stop) begin
            state_d = IDLE;
          end else if (start) begin
            state_d  = RUN;
            win_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (count_en && inc[i]) begin
        if (&cnt_q[i]) ovf_set[i] = 1'b1;
        else           cnt_nxt[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      if (rd_sel == SEL_WIDTH'(i)) rd_mux = shadow_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      running        <= 1'b0;
      rd_data        <= '0;
      overflow       <= '0;
      snapshot_valid <= 1'b0;
      win_rem        <= '0;
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
      rd_data <= rd_mux;

      if (win_load)     win_rem <= window_len;
      else if (win_dec) win_rem <= win_rem - WIN_ONE;

      if (clear) begin
        overflow       <= '0;
        snapshot_valid <= 1'b0;
        for (int i = 0; i <= NUM_EVENTS; i++) begin
          cnt_q[i]    <= '0;
          shadow_q[i] <= '0;
        end
      end else begin
        overflow <= overflow | ovf_set;
        cnt_q    <= cnt_nxt;
        if (win_load) snapshot_valid <= 1'b0;
        // The window-end snapshot includes the final cycle's increments and
        // takes precedence over a coincident manual request.
        if (auto_snap) begin
          shadow_q       <= cnt_nxt;
          snapshot_valid <= 1'b1;
        end else if (snapshot_req) begin
          shadow_q       <= cnt_q;
          snapshot_valid <= 1'b1;
        end
      end
    end
  end

`ifdef PERF_IRQ_EN
  // irq_hold remembers that the window ended with an overflow pending, which
  // keeps irq asserted until clear instead of a single-cycle pulse.
  logic irq_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq      <= 1'b0;
      irq_hold <= 1'b0;
    end else if (clear) begin
      irq      <= 1'b0;
      irq_hold <= 1'b0;
    end else if (auto_snap) begin
      irq      <= 1'b1;
      irq_hold <= |(overflow | ovf_set);
    end else begin
      irq <= irq_hold;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_event_counter.sv
module tb_perf_event_counter;
  localparam int NE  = 4;
  localparam int CW  = 6;
  localparam int WW  = 16;
  localparam int SW  = 5;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [NE-1:0] event_in;
  logic          start, stop, clear, snapshot_req;
  logic [WW-1:0] window_len;
  logic [SW-1:0] rd_sel;
  logic [CW-1:0] rd_data;
  logic          snapshot_valid;
  logic [NE:0]   overflow;
  logic          running;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integer counts, index NE is the cycle count.
  int m_cnt[NE+1];
  int m_sh[NE+1];
  bit m_ovf[NE+1];
  bit m_sv, m_counting, m_irq, m_irq_hold;
  int m_wrem, m_rd;

  perf_event_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .WIN_WIDTH(WW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .start(start), .stop(stop),
    .clear(clear), .window_len(window_len), .snapshot_req(snapshot_req),
    .rd_sel(rd_sel), .rd_data(rd_data), .snapshot_valid(snapshot_valid),
    .overflow(overflow), .running(running), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= NE; i++) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0;
    end
    m_sv = 0; m_counting = 0; m_irq = 0; m_irq_hold = 0; m_wrem = 0; m_rd = 0;
  endtask

  task automatic model_step();
    int  old[NE+1];
    int  nrd;
    bit  started, ended, any_ovf;
    old = m_cnt;
    nrd = (int'(rd_sel) <= NE) ? m_sh[rd_sel] : 0;
    started = 0; ended = 0;
    if (clear) begin
      for (int i = 0; i <= NE; i++) begin
        m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0;
      end
      m_sv = 0; m_irq = 0; m_irq_hold = 0;
    end else begin
      if (m_counting) begin
        if (stop) m_counting = 0;
        else begin
          for (int i = 0; i <= NE; i++) begin
            if (i == NE || event_in[i]) begin
              if (m_cnt[i] == MAX) m_ovf[i] = 1;
              else m_cnt[i] = m_cnt[i] + 1;
            end
          end
          if (m_wrem > 0) begin
            m_wrem = m_wrem - 1;
            if (m_wrem == 0) begin ended = 1; m_counting = 0; end
          end
        end
      end else if (!stop && start) begin
        started = 1; m_counting = 1; m_wrem = int'(window_len);
      end
      if (started) m_sv = 0;
      if (ended) begin m_sh = m_cnt; m_sv = 1; end
      else if (snapshot_req) begin m_sh = old; m_sv = 1; end
      any_ovf = 0;
      for (int i = 0; i <= NE; i++) any_ovf |= m_ovf[i];
      if (ended) begin m_irq = 1; m_irq_hold = any_ovf; end
      else m_irq = m_irq_hold;
    end
    m_rd = nrd;
  endtask

  task automatic tick();
    logic [NE:0] ov;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i <= NE; i++) ov[i] = m_ovf[i];
    chk("rd_data", rd_data, m_rd);
    chk("snapshot_valid", snapshot_valid, m_sv);
    chk("overflow", overflow, ov);
    chk("running", running, m_counting);
`ifdef PERF_IRQ_EN
    chk("irq", irq, m_irq);
`else
    chk("irq", irq, 0);
`endif
  endtask

  task automatic drive(input logic [NE-1:0] ev, input logic st, input logic sp, input logic cl,
                       input int wl, input logic sr, input int sel);
    event_in = ev; start = st; stop = sp; clear = cl;
    window_len = WW'(wl); snapshot_req = sr; rd_sel = SW'(sel);
    tick();
    start = 0; stop = 0; clear = 0; snapshot_req = 0;
  endtask

  initial begin
    reset = 1; event_in = 0; start = 0; stop = 0; clear = 0;
    window_len = 0; snapshot_req = 0; rd_sel = 0;
    model_reset();
    #12;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_running", running, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_snapshot_valid", snapshot_valid, 0);
    reset = 0;
    @(posedge clk); #1;

    // Free-run: 20 cycles of event 0
    drive('0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(4'b0001, 0, 0, 0, 0, 0, 0);
    drive(4'b0001, 0, 1, 0, 0, 0, 0);
    chk("freerun_running_after_stop", running, 0);
    drive('0, 0, 0, 0, 0, 1, 0);
    drive('0, 0, 0, 0, 0, 0, 0);
    chk("freerun_ch0", rd_data, 20);
    drive('0, 0, 0, 0, 0, 0, NE);
    chk("freerun_cycle", rd_data, 20);

    // Window of 10, event 1 on alternate cycles
    drive('0, 0, 0, 1, 0, 0, 0);
    drive('0, 1, 0, 0, 10, 0, 0);
    chk("window_sv_cleared", snapshot_valid, 0);
    for (int k = 0; k < 10; k++) drive((k % 2 == 0) ? 4'b0010 : 4'b0000, 0, 0, 0, 3, 0, 0);
    chk("window_done_sv", snapshot_valid, 1);
    chk("window_done_running", running, 0);
`ifdef PERF_IRQ_EN
    chk("window_irq_high", irq, 1);
`endif
    drive('0, 0, 0, 0, 0, 0, 1);
    chk("window_ch1", rd_data, 5);
`ifdef PERF_IRQ_EN
    chk("window_irq_pulse_end", irq, 0);
`endif
    drive('0, 0, 0, 0, 0, 0, NE);
    chk("window_cycle", rd_data, 10);

    // Read port: rd_sel 0 -> 1 -> 7
    drive('0, 0, 0, 0, 0, 0, 0);
    chk("rdport_sel0", rd_data, 0);
    drive('0, 0, 0, 0, 0, 0, 1);
    chk("rdport_sel1", rd_data, 5);
    drive('0, 0, 0, 0, 0, 0, 7);
    chk("rdport_sel7", rd_data, 0);

    // Saturation: event 2 held for 70 cycles
    drive('0, 0, 0, 1, 0, 0, 0);
    drive('0, 1, 0, 0, 0, 0, 2);
    for (int k = 0; k < 70; k++) drive(4'b0100, 0, 0, 0, 0, 0, 2);
    drive('0, 0, 1, 0, 0, 0, 2);
    drive('0, 0, 0, 0, 0, 1, 2);
    drive('0, 0, 0, 0, 0, 0, 2);
    chk("sat_ch2", rd_data, MAX);
    chk("sat_ovf2", overflow[2], 1);
    drive('0, 0, 0, 1, 0, 0, 2);
    chk("sat_ovf_cleared", overflow, 0);

    // Collisions
    drive('0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(4'b1111, 0, 0, 0, 0, 0, 0);
    drive(4'b1111, 0, 0, 1, 0, 1, 0);
    chk("collide_sv", snapshot_valid, 0);
    drive('0, 0, 1, 0, 0, 0, 3);
    drive('0, 0, 0, 0, 0, 0, 3);
    chk("collide_shadow", rd_data, 0);
    drive('0, 1, 1, 0, 0, 0, 0);
    chk("startstop_idle", running, 0);

    // Random stimulus
    for (int k = 0; k < 3000; k++) begin
      drive(NE'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 39) == 0), $urandom_range(0, 12),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 7));
    end

    // Reset mid-RUN with ch0 at 50
    drive('0, 0, 0, 1, 0, 0, 0);
    drive('0, 0, 1, 0, 0, 0, 0);
    drive('0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 50; k++) drive(4'b0001, 0, 0, 0, 0, 0, 0);
    drive('0, 0, 0, 0, 0, 1, 0);
    drive('0, 0, 0, 0, 0, 0, 0);
    chk("prereset_ch0", rd_data, 50);
    chk("prereset_running", running, 1);
    #2 reset = 1;
    #1;
    chk("async_rd_data", rd_data, 0);
    chk("async_running", running, 0);
    chk("async_sv", snapshot_valid, 0);
    chk("async_overflow", overflow, 0);
    chk("async_irq", irq, 0);
    model_reset();
    #1 reset = 0;
    drive('0, 0, 0, 0, 0, 1, 0);
    drive('0, 0, 0, 0, 0, 0, 0);
    chk("postreset_ch0", rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
